io_display_bcd: RTL and testbench
=================================

# io_display_bcd

Parametrised sequential decimal display driver for the 7-segment output port. On an `IO` strobe it captures the processor output word, converts it to BCD with an iterative shift-add-3 engine (no hardware dividers), then drives a configurable number of active-low 7-segment digits. It adds signed display, leading-zero blanking and overflow indication. It sits between the datapath result bus `saida` and the board displays.

## Interface
- `DATA_W`, 32, width of `saida`; must be ≥ 4
- `DIGITS`, 8, number of 7-segment digits driven; must be ≥ 2
- `SIGNED`, 0, 1 = `saida` is two's complement; negative values shown with a minus sign
- `BLANK_LZ`, 1, 1 = leading zeros blanked; 0 = all digits shown
- `sys_clock`  in  1  system clock; all state updates on the falling edge
- `reset`  in  1  synchronous, active-low reset, sampled on the falling edge of `sys_clock`
- `IO`  in  1  load strobe; samples `saida` when the block is idle
- `saida`  in  DATA_W  value to display
- `displays`  out  7*DIGITS  digit k at bits [7k+6:7k]; digit 0 is least significant; segments active-low, bit 6 = g
- `busy`  out  1  high while a conversion is in progress
- `done`  out  1  one-cycle pulse when `displays` update
- `overflow`  out  1  last converted value did not fit; held until the next update

## Operation
- Segment codes: 0–9 as 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit). Blank = 7F. Dash = 3F.
- States: IDLE, CONV, UPDATE.
- **IDLE**, `IO`=1:
  - Capture the magnitude of `saida` into the shift register. When `SIGNED`=1 and the MSB is set, take the two's-complement magnitude and set `neg`. The magnitude of −2^(DATA_W−1) fits in DATA_W bits.
  - Clear the BCD accumulator (4*DIGITS bits) and the bit counter.
  - Go to CONV.
- **IDLE**, `IO`=0: no action.
- **CONV**, one bit per cycle for DATA_W cycles:
  - For every nibble ≥5, add 3.
  - Shift accumulator left 1, shifting in the shift register MSB.
  - Any 1 shifted out of the accumulator top sets internal `ovf`.
  - Go to UPDATE after the DATA_W-th shift.
- **UPDATE**:
  - Define the significant digit count n = index of the highest nonzero nibble + 1 (minimum 1).
  - Overflow condition: `ovf`, or `neg` with n = DIGITS.
  - On overflow: all digits show dash and `overflow`=1.
  - Otherwise, `overflow`=0 and each digit shows its BCD code.
  - With `BLANK_LZ`=1, digits ≥ n show blank.
  - When `neg`: digit n shows dash if `BLANK_LZ`=1; digit DIGITS−1 shows dash if `BLANK_LZ`=0.
  - Pulse `done` and return to IDLE.
- `IO` is ignored outside IDLE. A new `IO` in IDLE always restarts conversion from the current `saida`.
- `displays` hold their value between updates and change only in UPDATE or reset.

## Timing
- Reset (`reset`=0 at a falling edge):
  - All digits = 40 ("0"), regardless of `BLANK_LZ`.
  - `busy`=0, `done`=0, `overflow`=0; state IDLE.
  - Any conversion in progress is aborted.
- Load edge L (IDLE, `IO`=1): `busy`=1 from edge L.
- CONV occupies edges L+1 … L+DATA_W.
- Edge L+DATA_W+1:
  - `displays` and `overflow` update.
  - `done`=1 for exactly that cycle; `busy`=0.
  - State returns to IDLE.
- Total latency from load to displayed value: DATA_W+1 falling edges (33 for the default).
- `IO`=1 on edge L+DATA_W+2 is accepted, giving back-to-back conversions with throughput of one per DATA_W+2 cycles.
- `saida` need only be stable at edge L; later changes do not affect the conversion.
- Reset wins over every other event on the same edge.

## Test plan
- **Reset**: hold `reset`=0 for 2 edges. Required: all 8 digits = 40, `busy`=0, `done`=0, `overflow`=0.
- **Unsigned, blanked**: `saida`=1234, pulse `IO` (defaults). Required:
  - `done` exactly 33 edges after load.
  - digits 3..0 = 79,24,30,19; digits 7..4 = 7F; `overflow`=0.
- **Range limits**:
  - `saida`=99999999: all digits = 10, `overflow`=0.
  - Then `saida`=100000000: all digits = 3F, `overflow`=1.
  - Then `saida`=5: `overflow` returns to 0.
- **Signed** (`SIGNED`=1), `saida`=32'hFFFFFFD3 (−45). Required:
  - digit0 = 12, digit1 = 19, digit2 = 3F, digits 7..3 = 7F.
  - With `BLANK_LZ`=0: digits 6..2 = 40, digit7 = 3F.
- **Zero**: `saida`=0. Required: digit0 = 40, others 7F. With `BLANK_LZ`=0: all digits = 40.
- **Abort and ignore**:
  - `IO` re-pulsed with a new value mid-conversion is ignored: the first value is displayed and `done` occurs once.
  - `reset`=0 at edge L+10: no `done`, all digits = 40, `busy`=0.

Source files
------------

// File: rtl/io_display_bcd.sv
// io_display_bcd: captures saida on IO and converts it to BCD one bit per cycle (shift-add-3), then drives active-low 7-segment digits.
// Latency: DATA_W+1 falling edges from the load edge to updated displays and the done pulse; one conversion per DATA_W+2 cycles back-to-back.
// Backpressure: IO is honoured only in IDLE (busy=0); strobes during a conversion are dropped, and reset aborts any conversion.
module io_display_bcd #(
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 8,
  parameter int SIGNED   = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  IO,
  input  logic [DATA_W-1:0]     saida,
  output logic [7*DIGITS-1:0]   displays,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_UPDATE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic                ovf_q;
  logic [7*DIGITS-1:0] displays_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;

  logic [BCD_W-1:0]    bcd_adj_d;
  logic [DATA_W-1:0]   mag_d;
  logic                neg_d;
  logic [7*DIGITS-1:0] displays_d;
  logic                overflow_d;
  int                  nsig;

  // Digit decode: 0-9 to active-low segments (g = bit 6); anything else blank.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Magnitude and sign of the incoming word; -2^(DATA_W-1) maps to 2^(DATA_W-1), which still fits unsigned.
  always_comb begin
    neg_d = (SIGNED != 0) && saida[DATA_W-1];
    mag_d = neg_d ? (~saida + 1'b1) : saida;
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Segment image for the finished BCD value: significance, sign placement, blanking, overflow dashes.
  always_comb begin
    nsig = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) nsig = i + 1;
    end
    // A negative value needs one spare digit for its minus sign.
    overflow_d = ovf_q || (neg_q && (nsig == DIGITS));
    displays_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      logic [6:0] seg;
      seg = seg_of(bcd_q[4*k +: 4]);
      if (overflow_d) begin
        seg = SEG_DASH;
      end else begin
        if ((BLANK_LZ != 0) && (k >= nsig)) seg = SEG_BLANK;
        if (neg_q) begin
          if ((BLANK_LZ != 0) && (k == nsig)) seg = SEG_DASH;
          if ((BLANK_LZ == 0) && (k == DIGITS - 1)) seg = SEG_DASH;
        end
      end
      displays_d[7*k +: 7] = seg;
    end
  end

  // Control FSM and datapath registers; all state moves on the falling edge, reset first.
  always_ff @(negedge sys_clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      displays_q <= {DIGITS{SEG_ZERO}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (IO) begin
            shreg_q <= mag_d;
            neg_q   <= neg_d;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q   <= {bcd_adj_d[BCD_W-2:0], shreg_q[DATA_W-1]};
          shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
          if (bcd_adj_d[BCD_W-1]) ovf_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          displays_q <= displays_d;
          overflow_q <= overflow_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign displays = displays_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_io_display_bcd.sv
// Bench for io_display_bcd: three instances (unsigned/blanked, signed/blanked, signed/unblanked) share stimulus.
// A scoreboard queue holds expected images from a decimal reference model; a monitor checks on every done pulse.
module tb_io_display_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io = 1'b0;
  logic [31:0] saida = '0;

  logic [55:0] disp_u, disp_s, disp_z;
  logic        busy_u, busy_s, busy_z;
  logic        done_u, done_s, done_z;
  logic        ovf_u, ovf_s, ovf_z;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [55:0] du, ds, dz;
    logic        ou, os, oz;
    int          edge_at;
  } exp_t;
  exp_t exp_q[$];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [55:0] all_zero = {8{7'h40}};

  io_display_bcd #(.DATA_W(32), .DIGITS(8), .SIGNED(0), .BLANK_LZ(1)) dut_u (
    .sys_clock(clk), .reset(rst_n), .IO(io), .saida(saida),
    .displays(disp_u), .busy(busy_u), .done(done_u), .overflow(ovf_u));
  io_display_bcd #(.DATA_W(32), .DIGITS(8), .SIGNED(1), .BLANK_LZ(1)) dut_s (
    .sys_clock(clk), .reset(rst_n), .IO(io), .saida(saida),
    .displays(disp_s), .busy(busy_s), .done(done_s), .overflow(ovf_s));
  io_display_bcd #(.DATA_W(32), .DIGITS(8), .SIGNED(1), .BLANK_LZ(0)) dut_z (
    .sys_clock(clk), .reset(rst_n), .IO(io), .saida(saida),
    .displays(disp_z), .busy(busy_z), .done(done_z), .overflow(ovf_z));

  always #5 clk = ~clk;
  always @(negedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal reference: plain arithmetic on the value, digit by digit.
  function automatic void model(input logic [31:0] v, input bit sgn, input bit blz,
                                output logic [55:0] disp, output logic ovf);
    longint unsigned mag, t;
    bit neg;
    int d [8];
    int n;
    neg = sgn && v[31];
    mag = neg ? (64'h1_0000_0000 - 64'(v)) : 64'(v);
    ovf = (mag >= 64'd100000000) || (neg && mag >= 64'd10000000);
    t = mag;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(t % 10);
      t = t / 10;
    end
    n = 1;
    for (int i = 0; i < 8; i++) if (d[i] != 0) n = i + 1;
    disp = '0;
    for (int k = 0; k < 8; k++) begin
      logic [6:0] s;
      if (ovf) s = 7'h3F;
      else if (blz && k >= n) s = 7'h7F;
      else s = seg_tab[d[k]];
      if (!ovf && neg && ((blz && k == n) || (!blz && k == 7))) s = 7'h3F;
      disp[7*k +: 7] = s;
    end
  endfunction

  // Issue a load at the next falling edge once idle; optionally record the expectation.
  task automatic issue(input logic [31:0] v, input bit expect_done, output int load_edge);
    exp_t e;
    int guard = 0;
    @(posedge clk);
    while (busy_u && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL idle_wait: busy still %b after %0d cycles, required 0", busy_u, guard);
    end
    saida = v;
    io = 1'b1;
    load_edge = edge_cnt + 1;
    if (expect_done) begin
      model(v, 1'b0, 1'b1, e.du, e.ou);
      model(v, 1'b1, 1'b1, e.ds, e.os);
      model(v, 1'b1, 1'b0, e.dz, e.oz);
      e.edge_at = load_edge + 33;
      exp_q.push_back(e);
    end
    @(posedge clk);
    io = 1'b0;
    saida = $urandom;
  endtask

  task automatic load(input logic [31:0] v);
    int le;
    issue(v, 1'b1, le);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(posedge clk) begin
    if (done_u || done_s || done_z) begin
      chk("done_sync", {61'd0, done_u, done_s, done_z}, 64'h7);
      chk("busy_at_done", {61'd0, busy_u, busy_s, busy_z}, 64'h0);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: done=1 at edge %0d, required no done", edge_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_edge", 64'(edge_cnt), 64'(e.edge_at));
        chk("disp_u", 64'(disp_u), 64'(e.du));
        chk("disp_s", 64'(disp_s), 64'(e.ds));
        chk("disp_z", 64'(disp_z), 64'(e.dz));
        chk("ovf_u", 64'(ovf_u), 64'(e.ou));
        chk("ovf_s", 64'(ovf_s), 64'(e.os));
        chk("ovf_z", 64'(ovf_z), 64'(e.oz));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_disp_u"}, 64'(disp_u), 64'(all_zero));
    chk({tag, "_disp_s"}, 64'(disp_s), 64'(all_zero));
    chk({tag, "_disp_z"}, 64'(disp_z), 64'(all_zero));
    chk({tag, "_busy"}, {61'd0, busy_u, busy_s, busy_z}, 64'h0);
    chk({tag, "_done"}, {61'd0, done_u, done_s, done_z}, 64'h0);
    chk({tag, "_ovf"}, {61'd0, ovf_u, ovf_s, ovf_z}, 64'h0);
  endtask

  initial begin
    int le;
    logic [31:0] v;
    // Reset for two falling edges.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Unsigned blanked value.
    load(32'd1234);
    wait_drain();
    chk("u_1234", 64'(disp_u), 64'({{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19}));

    // Range limits, issued back to back.
    load(32'd99999999);
    load(32'd100000000);
    load(32'd5);
    wait_drain();
    chk("u_5_ovf", 64'(ovf_u), 64'h0);

    // Signed -45.
    load(32'hFFFFFFD3);
    wait_drain();
    chk("s_m45", 64'(disp_s), 64'({{5{7'h7F}}, 7'h3F, 7'h19, 7'h12}));
    chk("z_m45", 64'(disp_z), 64'({7'h3F, {5{7'h40}}, 7'h19, 7'h12}));

    // Zero.
    load(32'd0);
    wait_drain();
    chk("u_zero", 64'(disp_u), 64'({{7{7'h7F}}, 7'h40}));
    chk("z_zero", 64'(disp_z), 64'(all_zero));

    // Sign and range boundaries.
    load(32'd10000000);
    load(32'hFF676981);   // -9999999
    load(32'hFF676980);   // -10000000
    load(32'h80000000);
    load(32'hFFFFFFFF);
    load(32'd9);
    load(32'd10);
    wait_drain();

    // IO re-pulsed mid conversion with a new value is ignored.
    load(32'd777);
    repeat (5) @(posedge clk);
    saida = 32'd12345;
    io = 1'b1;
    @(posedge clk);
    io = 1'b0;
    wait_drain();
    repeat (40) @(posedge clk);

    // Reset at edge L+10 aborts the conversion.
    issue(32'd4321, 1'b0, le);
    while (edge_cnt < le + 9) @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    check_reset_state("abort");
    repeat (40) @(posedge clk);
    chk("abort_disp_u", 64'(disp_u), 64'(all_zero));

    // Randomised values over several magnitude classes.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 99999999));
        2: v = 32'($urandom_range(0, 999));
        default: begin
          v = 32'($urandom_range(0, 9999999));
          v = -v;
        end
      endcase
      load(v);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    wait_drain();
    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
